// File: rtl/gfx_pkg.sv
// Shared types and constants for the viewport transform pipeline.
package gfx_pkg;
   typedef enum logic [3:0] {
      IDLE, ADDR, FETCH_X, FETCH_Y, FETCH_Z, DIV_X, DIV_Y, MAP, EMIT
   } state_t;

   localparam int FRAC_BITS = 16;
   localparam int WORDS_PER_VERTEX = 3;
   localparam logic [31:0] DEFAULT_NEAR_Z = 32'h0000_1000;
endpackage

// File: rtl/fixed_div.sv
// Signed Q16.16 divide: restoring radix-2 on magnitudes, 34 cycles from start to done.
module fixed_div
   import gfx_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic signed [31:0] dividend,
   input  logic signed [31:0] divisor,
   output logic               done,
   output logic signed [31:0] quotient
);
   logic [31:0] rem_reg, dq_reg, den_reg;
   logic [5:0]  cnt_reg;
   logic        busy_reg, neg_reg, ovf_reg;
   logic [31:0] num_mag, den_mag, rem_sub, q_mag;
   logic [32:0] trial;
   logic        take;

   assign num_mag = dividend[31] ? -dividend : dividend;
   assign den_mag = divisor[31] ? -divisor : divisor;
   assign trial   = {rem_reg, dq_reg[31]};
   assign take    = trial >= {1'b0, den_reg};
   assign rem_sub = trial[31:0] - den_reg;
   // Quotients that do not fit a signed 32-bit word saturate to full scale.
   assign q_mag   = (ovf_reg || dq_reg[31]) ? 32'h7FFF_FFFF : dq_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_reg <= 1'b0;
         done     <= 1'b0;
         cnt_reg  <= 6'd0;
         rem_reg  <= 32'd0;
         dq_reg   <= 32'd0;
         den_reg  <= 32'd0;
         neg_reg  <= 1'b0;
         ovf_reg  <= 1'b0;
         quotient <= 32'sd0;
      end else begin
         done <= 1'b0;
         if (start) begin
            // Dividend is |n|<<16; its top 16 bits seed the remainder so 32 steps suffice.
            busy_reg <= 1'b1;
            cnt_reg  <= 6'd32;
            rem_reg  <= {16'd0, num_mag[31:FRAC_BITS]};
            dq_reg   <= {num_mag[FRAC_BITS-1:0], 16'd0};
            den_reg  <= den_mag;
            neg_reg  <= dividend[31] ^ divisor[31];
            ovf_reg  <= {16'd0, num_mag[31:FRAC_BITS]} >= den_mag;
         end else if (busy_reg) begin
            if (cnt_reg != 6'd0) begin
               rem_reg <= take ? rem_sub : trial[31:0];
               dq_reg  <= {dq_reg[30:0], take};
               cnt_reg <= cnt_reg - 6'd1;
            end else begin
               quotient <= neg_reg ? -$signed(q_mag) : $signed(q_mag);
               done     <= 1'b1;
               busy_reg <= 1'b0;
            end
         end
      end
   end
endmodule

// File: rtl/viewport_pipe.sv
// Fetches Q16.16 vertices from RAM, perspective-divides x/y by z and maps them to screen pixels.
module viewport_pipe
   import gfx_pkg::*;
#(
   parameter int          SCREEN_W = 320,
   parameter int          SCREEN_H = 240,
   parameter logic [31:0] NEAR_Z   = DEFAULT_NEAR_Z
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] count,
   output logic        done,
   output logic [31:0] result_addr,
   input  logic [31:0] result_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [8:0]  out_x,
   output logic [7:0]  out_y,
   output logic [31:0] out_z,
   output logic        out_clip,
   output logic        out_last
);
   localparam logic signed [47:0] HALF_W = 48'(SCREEN_W / 2);
   localparam logic signed [47:0] HALF_H = 48'(SCREEN_H / 2);
   localparam logic signed [47:0] MAX_X  = 48'(SCREEN_W - 1);
   localparam logic signed [47:0] MAX_Y  = 48'(SCREEN_H - 1);

   state_t             state_reg;
   logic [31:0]        count_reg, vtx_reg;
   logic signed [31:0] x_reg, y_reg, z_reg, ndc_x_reg, ndc_y_reg;
   logic signed [31:0] div_num, div_den, div_q;
   logic               div_start, div_done, z_clip, last_vtx, map_clip;
   logic signed [47:0] ndc_x_w, ndc_y_w, prod_x, prod_y, sx, sy;

   assign z_clip   = $signed(result_data) <= $signed(NEAR_Z);
   assign last_vtx = vtx_reg == count_reg - 32'd1;

   // x divide launches while z is still on the RAM bus; y launches as x completes.
   assign div_start = ((state_reg == FETCH_Z) && !z_clip) || ((state_reg == DIV_X) && div_done);
   assign div_num   = (state_reg == FETCH_Z) ? x_reg : y_reg;
   assign div_den   = (state_reg == FETCH_Z) ? $signed(result_data) : z_reg;

   fixed_div u_div (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .dividend (div_num),
      .divisor  (div_den),
      .done     (div_done),
      .quotient (div_q)
   );

   assign ndc_x_w  = 48'(ndc_x_reg);
   assign ndc_y_w  = 48'(ndc_y_reg);
   assign prod_x   = ndc_x_w * HALF_W;
   assign prod_y   = ndc_y_w * HALF_H;
   assign sx       = HALF_W + (prod_x >>> FRAC_BITS);
   assign sy       = HALF_H - (prod_y >>> FRAC_BITS);
   assign map_clip = (sx < 48'sd0) || (sx > MAX_X) || (sy < 48'sd0) || (sy > MAX_Y);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg   <= IDLE;
         done        <= 1'b1;
         result_addr <= 32'd0;
         out_valid   <= 1'b0;
         out_x       <= 9'd0;
         out_y       <= 8'd0;
         out_z       <= 32'd0;
         out_clip    <= 1'b0;
         out_last    <= 1'b0;
         count_reg   <= 32'd0;
         vtx_reg     <= 32'd0;
         x_reg       <= 32'sd0;
         y_reg       <= 32'sd0;
         z_reg       <= 32'sd0;
         ndc_x_reg   <= 32'sd0;
         ndc_y_reg   <= 32'sd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start && (count != 32'd0)) begin
                  count_reg   <= count;
                  vtx_reg     <= 32'd0;
                  result_addr <= 32'd0;
                  done        <= 1'b0;
                  state_reg   <= ADDR;
               end
            end
            ADDR: begin
               result_addr <= result_addr + 32'd1;
               state_reg   <= FETCH_X;
            end
            FETCH_X: begin
               x_reg       <= $signed(result_data);
               result_addr <= result_addr + 32'd1;
               state_reg   <= FETCH_Y;
            end
            FETCH_Y: begin
               y_reg     <= $signed(result_data);
               state_reg <= FETCH_Z;
            end
            FETCH_Z: begin
               z_reg <= $signed(result_data);
               if (z_clip) begin
                  out_valid <= 1'b1;
                  out_clip  <= 1'b1;
                  out_x     <= 9'd0;
                  out_y     <= 8'd0;
                  out_z     <= result_data;
                  out_last  <= last_vtx;
                  state_reg <= EMIT;
               end else begin
                  state_reg <= DIV_X;
               end
            end
            DIV_X: begin
               if (div_done) begin
                  ndc_x_reg <= div_q;
                  state_reg <= DIV_Y;
               end
            end
            DIV_Y: begin
               if (div_done) begin
                  ndc_y_reg <= div_q;
                  state_reg <= MAP;
               end
            end
            MAP: begin
               out_valid <= 1'b1;
               out_clip  <= map_clip;
               out_x     <= map_clip ? 9'd0 : sx[8:0];
               out_y     <= map_clip ? 8'd0 : sy[7:0];
               out_z     <= z_reg;
               out_last  <= last_vtx;
               state_reg <= EMIT;
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (last_vtx) begin
                     done      <= 1'b1;
                     state_reg <= IDLE;
                  end else begin
                     vtx_reg     <= vtx_reg + 32'd1;
                     result_addr <= result_addr + 32'd1;
                     state_reg   <= ADDR;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_viewport_pipe.sv
// Self-checking bench for viewport_pipe: directed table, random batches, reset and stall sequences.
module tb_viewport_pipe;
   localparam logic signed [31:0] NEAR = 32'sh0000_1000;

   logic        clock = 1'b0;
   logic        reset, start, out_ready;
   logic [31:0] count, result_addr, result_data, out_z;
   logic        done, out_valid, out_clip, out_last;
   logic [8:0]  out_x;
   logic [7:0]  out_y;

   viewport_pipe dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .count       (count),
      .done        (done),
      .result_addr (result_addr),
      .result_data (result_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_x       (out_x),
      .out_y       (out_y),
      .out_z       (out_z),
      .out_clip    (out_clip),
      .out_last    (out_last)
   );

   always #5 clock = ~clock;

   logic [31:0] mem [0:63];
   always @(posedge clock) result_data <= mem[result_addr[5:0]];

   typedef struct {
      logic [31:0] x, y, z;
      logic        clip;
      int          ex, ey;
   } vec_t;

   vec_t        batch[$];
   vec_t        table_v[$];
   logic [31:0] addr_q[$];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock step; also logs every distinct RAM address the DUT presents.
   task automatic tick();
      @(negedge clock);
      if (addr_q.size() == 0 || addr_q[$] != result_addr) addr_q.push_back(result_addr);
   endtask

   // Reference: exact rational divide on 64-bit integers, truncated toward zero, saturated.
   function automatic longint ndc(input logic [31:0] n, input logic [31:0] d);
      longint a, b, q;
      bit     neg;
      a = longint'($signed(n));
      b = longint'($signed(d));
      neg = (a < 0) != (b < 0);
      if (a < 0) a = -a;
      if (b < 0) b = -b;
      q = (a * 65536) / b;
      if (q > 64'sh7FFF_FFFF) q = 64'sh7FFF_FFFF;
      return neg ? -q : q;
   endfunction

   function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      vec_t   v;
      longint sx, sy;
      v.x = x; v.y = y; v.z = z;
      if ($signed(z) <= NEAR) begin
         v.clip = 1'b1; v.ex = 0; v.ey = 0;
         return v;
      end
      sx = 160 + ((ndc(x, z) * 160) >>> 16);
      sy = 120 - ((ndc(y, z) * 120) >>> 16);
      v.clip = (sx < 0) || (sx > 319) || (sy < 0) || (sy > 239);
      v.ex = v.clip ? 0 : int'(sx);
      v.ey = v.clip ? 0 : int'(sy);
      return v;
   endfunction

   function automatic vec_t dv(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                               input logic clip, input int ex, input int ey);
      vec_t v;
      v.x = x; v.y = y; v.z = z; v.clip = clip; v.ex = ex; v.ey = ey;
      return v;
   endfunction

   task automatic run_batch(input string tag, input int stall_at, input int stall_len,
                            input bit poke_start, output int lat);
      int n, w, bad;
      logic [51:0] snap;
      n = batch.size();
      lat = -1;
      for (int i = 0; i < n; i++) begin
         mem[3*i]   = batch[i].x;
         mem[3*i+1] = batch[i].y;
         mem[3*i+2] = batch[i].z;
      end
      @(negedge clock);
      start = 1'b1; count = n;
      addr_q.delete();
      tick();
      start = 1'b0; count = 0;
      chk({tag, " done_fall"}, done, 1'b0);
      w = 1;
      for (int k = 0; k < n; k++) begin
         while (!out_valid && w < 400) begin tick(); w++; end
         if (!out_valid) begin
            checks++; errors++;
            $display("FAIL %s timeout: beat %0d never valid", tag, k);
            return;
         end
         if (k == 0) lat = w;
         chk($sformatf("%s[%0d] out_x", tag, k), out_x, batch[k].ex);
         chk($sformatf("%s[%0d] out_y", tag, k), out_y, batch[k].ey);
         chk($sformatf("%s[%0d] out_clip", tag, k), out_clip, batch[k].clip);
         chk($sformatf("%s[%0d] out_z", tag, k), out_z, batch[k].z);
         chk($sformatf("%s[%0d] out_last", tag, k), out_last, k == n - 1);
         $display("beat %s[%0d] x=%0d y=%0d clip=%0d last=%0d", tag, k, out_x, out_y, out_clip, out_last);
         if (k == stall_at) begin
            snap = {out_valid, out_x, out_y, out_z, out_clip, out_last};
            bad = 0;
            for (int j = 0; j < stall_len; j++) begin
               if (poke_start && j == 2) begin start = 1'b1; count = 7; end
               if (poke_start && j == 3) begin start = 1'b0; count = 0; end
               tick();
               if ({out_valid, out_x, out_y, out_z, out_clip, out_last} !== snap) bad++;
            end
            start = 1'b0; count = 0;
            chk({tag, " stall_stable"}, bad, 0);
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         w = 1;
      end
      chk({tag, " done_rise"}, done, 1'b1);
      chk({tag, " valid_drop"}, out_valid, 1'b0);
      bad = (addr_q.size() != 3 * n) ? 1 : 0;
      for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i) bad++;
      chk({tag, " addr_seq"}, bad, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bad;
      reset = 1'b1; start = 1'b0; count = 0; out_ready = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      repeat (3) @(negedge clock);
      chk("rst done", done, 1'b1);
      chk("rst out_valid", out_valid, 1'b0);
      chk("rst out_last", out_last, 1'b0);
      chk("rst out_clip", out_clip, 1'b0);
      chk("rst out_xyz", {out_x, out_y, out_z}, 0);
      chk("rst result_addr", result_addr, 0);
      reset = 1'b0;

      table_v.push_back(dv(32'h0, 32'h0, 32'h10000, 0, 160, 120));
      table_v.push_back(dv(32'h8000, 32'hFFFF8000, 32'h10000, 0, 240, 180));
      table_v.push_back(dv(32'h10000, 32'h10000, 32'h20000, 0, 240, 60));
      table_v.push_back(dv(32'h0, 32'h0, 32'h800, 1, 0, 0));
      table_v.push_back(dv(32'h10000, 32'h10000, 32'hFFFF0000, 1, 0, 0));
      table_v.push_back(dv(32'h20000, 32'h0, 32'h10000, 1, 0, 0));
      table_v.push_back(dv(32'hFD70, 32'h0, 32'h10000, 0, 318, 120));
      table_v.push_back(dv(32'h0, 32'h0, 32'h1000, 1, 0, 0));
      table_v.push_back(dv(32'h0, 32'h0, 32'h1001, 0, 160, 120));
      table_v.push_back(dv(32'hFFFF0000, 32'h10000, 32'h10000, 0, 0, 0));
      table_v.push_back(dv(32'h10000, 32'h0, 32'h10000, 1, 0, 0));
      table_v.push_back(dv(32'h0, 32'hFFFF0000, 32'h10000, 1, 0, 0));
      table_v.push_back(dv(32'hFFFFFFFF, 32'h0, 32'h30000, 0, 160, 120));
      table_v.push_back(dv(32'h7FFFFFFF, 32'h0, 32'h1001, 1, 0, 0));

      foreach (table_v[i]) begin
         batch.delete();
         batch.push_back(table_v[i]);
         run_batch($sformatf("vec%0d", i), -1, 0, 1'b0, lat);
         chk($sformatf("vec%0d latency", i), lat, ($signed(table_v[i].z) <= NEAR) ? 5 : 74);
      end

      // Three-vertex batch with a 10-cycle stall on vertex 1 and a start pulse mid-batch.
      batch.delete();
      batch.push_back(mk(32'h4000, 32'hFFFFC000, 32'h10000));
      batch.push_back(mk(32'h6000, 32'h2000, 32'h18000));
      batch.push_back(mk(32'h0, 32'h0, 32'h400));
      run_batch("stall3", 1, 10, 1'b1, lat);

      for (int r = 0; r < 6; r++) begin
         int n;
         logic [31:0] x, y, z;
         n = $urandom_range(1, 4);
         batch.delete();
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) z = $urandom_range(0, 32'h1800);
            else z = $urandom_range(32'h4000, 32'h40000);
            x = $urandom_range(0, 32'h30000) - 32'h18000;
            y = $urandom_range(0, 32'h30000) - 32'h18000;
            batch.push_back(mk(x, y, z));
         end
         run_batch($sformatf("rnd%0d", r), -1, 0, 1'b0, lat);
      end

      // Reset while the y divide is in flight, then a fresh batch must start cleanly.
      mem[0] = 32'h8000; mem[1] = 32'h8000; mem[2] = 32'h10000;
      @(negedge clock); start = 1'b1; count = 1;
      @(negedge clock); start = 1'b0; count = 0;
      repeat (50) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort done", done, 1'b1);
      chk("abort out_valid", out_valid, 1'b0);
      chk("abort result_addr", result_addr, 0);
      batch.delete();
      batch.push_back(mk(32'hFFFF8000, 32'h4000, 32'h10000));
      run_batch("after_abort", -1, 0, 1'b0, lat);
      chk("after_abort latency", lat, 74);

      // Reset while a beat is waiting in EMIT.
      mem[0] = 32'h0; mem[1] = 32'h0; mem[2] = 32'h800;
      @(negedge clock); start = 1'b1; count = 1;
      @(negedge clock); start = 1'b0; count = 0;
      bad = 0;
      while (!out_valid && bad < 20) begin @(negedge clock); bad++; end
      chk("emit_rst valid_seen", out_valid, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("emit_rst out_valid", out_valid, 1'b0);
      chk("emit_rst done", done, 1'b1);

      // count==0 start must be a no-op.
      @(negedge clock); start = 1'b1; count = 0;
      @(negedge clock); start = 1'b0;
      bad = 0;
      for (int i = 0; i < 80; i++) begin
         if (out_valid !== 1'b0 || done !== 1'b1) bad++;
         @(negedge clock);
      end
      chk("count0 idle", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
